// File: rtl/encoder83_pkg.sv
// encoder83_pkg
// Shared types and helpers for the registered 8-to-3 priority encoder.
// Exports the FSM state type, the idle level of the request lines after
// reset, and the pure encoding helpers used by both the RTL and any model.
package encoder83_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_OUTPUT   = 2'd2,
        S_RELEASE  = 2'd3
    } state_e;

    // Synchroniser reset value: all lines high, which is "nothing pressed"
    // for the default active-low request polarity.
    localparam logic [7:0] IDLE_LINES = 8'hFF;

    // Index of the highest set bit; bit 7 wins. Returns 0 for an all-zero input.
    function automatic logic [2:0] prio_enc8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // True when more than one bit is set: clearing the lowest set bit
    // leaves something behind only if a second bit existed.
    function automatic logic multi_hot8(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/encoder83_sync_if.sv
// encoder83_sync_if
// Request/handshake bundle between the request lines, the encoder and the
// downstream consumer.
//   i_y     : 8 raw request lines (asynchronous to the encoder clock)
//   i_opt   : request polarity, 0 = active-low, 1 = active-high
//   i_ready : consumer accepts the current code
//   o_valid : o_code/o_multi carry a debounced event
//   o_code  : index of the highest active request
//   o_multi : more than one request was active in the captured pattern
//   o_busy  : encoder FSM is not idle
// Modport slave is the encoder side, master the driver/consumer side.
interface encoder83_sync_if;
    import encoder83_pkg::*;

    logic [7:0] i_y;
    logic       i_opt;
    logic       i_ready;
    logic       o_valid;
    logic [2:0] o_code;
    logic       o_multi;
    logic       o_busy;

    modport slave (
        input  i_y,
        input  i_opt,
        input  i_ready,
        output o_valid,
        output o_code,
        output o_multi,
        output o_busy
    );

    modport master (
        output i_y,
        output i_opt,
        output i_ready,
        input  o_valid,
        input  o_code,
        input  o_multi,
        input  o_busy
    );

endinterface

// File: rtl/sync2_bus.sv
// sync2_bus
// Parameterised-width two-flop synchroniser for quasi-static or slowly
// changing buses. Each bit is synchronised independently; multi-bit
// coherence is left to the consumer (the encoder debounces the pattern).
//   clk_i : clock
//   rst_i : synchronous active-high reset, loads RST_VAL into both stages
//   d_i   : asynchronous input bus
//   q_o   : synchronised output bus (second stage)
module sync2_bus #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/encoder83_sync.sv
// encoder83_sync
// Registered 8-to-3 priority encoder with debounce and a valid/ready output.
// Request lines are synchronised, converted to an "active" vector according
// to the polarity input, and must hold one non-zero pattern for DEBOUNCE
// consecutive cycles before the highest active index is offered downstream.
// After acceptance all lines must be inactive for DEBOUNCE cycles before a
// new event can be qualified, so a held request never re-triggers.
//   i_clk : clock, all logic on the rising edge
//   i_rst : synchronous active-high reset
//   bus   : encoder83_sync_if.slave (i_y, i_opt, i_ready, o_valid,
//           o_code, o_multi, o_busy)
module encoder83_sync
    import encoder83_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    encoder83_sync_if.slave    bus
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic [7:0] sync_y;
    logic [7:0] act;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [7:0]       cap_q,   cap_d;
    logic             valid_q, valid_d;
    logic [2:0]       code_q,  code_d;
    logic             multi_q, multi_d;

    // ---- stage: input synchroniser ----
    sync2_bus #(
        .WIDTH   (8),
        .RST_VAL (IDLE_LINES)
    ) u_sync (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .d_i   (bus.i_y),
        .q_o   (sync_y)
    );

    // i_opt is quasi-static and only feeds this inversion, so a change while
    // busy just looks like a pattern change and is handled by the FSM rules.
    assign act = bus.i_opt ? sync_y : ~sync_y;

    // ---- stage: debounce / handshake FSM ----
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        valid_d = valid_q;
        code_d  = code_q;
        multi_d = multi_q;

        unique case (state_q)
            S_IDLE: begin
                if (act != 8'd0) begin
                    cap_d   = act;
                    cnt_d   = '0;
                    state_d = S_DEBOUNCE;
                end
            end

            S_DEBOUNCE: begin
                // Any change restarts qualification through S_IDLE.
                if (act != cap_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    code_d  = prio_enc8(cap_q);
                    multi_d = multi_hot8(cap_q);
                    valid_d = 1'b1;
                    state_d = S_OUTPUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_OUTPUT: begin
                // Outputs are frozen here; only acceptance moves us on.
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    code_d  = 3'd0;
                    multi_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end
            end

            S_RELEASE: begin
                if (act != 8'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cap_q   <= 8'd0;
            valid_q <= 1'b0;
            code_q  <= 3'd0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            multi_q <= multi_d;
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_code  = code_q;
    assign bus.o_multi = multi_q;
    assign bus.o_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_encoder83_sync.sv
module tb_encoder83_sync;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    encoder83_sync_if bus ();

    encoder83_sync #(.DEBOUNCE(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time
    // unit after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ticks until o_valid is seen, bounded to 30 edges; n = edges taken.
    task automatic wait_valid(output int n);
        n = 0;
        while (n < 30) begin
            tick(1);
            n++;
            if (bus.o_valid === 1'b1) break;
        end
    endtask

    int n;
    int hits;
    int seen_busy;

    initial begin
        total = 0;
        bad   = 0;
        rst          = 1'b1;
        bus.i_y      = 8'hFF;
        bus.i_opt    = 1'b0;
        bus.i_ready  = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_code",  32'(bus.o_code),  32'd0);
        check("rst_multi", 32'(bus.o_multi), 32'd0);
        check("rst_busy",  32'(bus.o_busy),  32'd0);
        tick(3);
        check("idle_busy", 32'(bus.o_busy), 32'd0);

        // Single press of bit 5, active-low, exact latency.
        bus.i_y = 8'b1101_1111;
        tick(6);
        check("lat_early_valid", 32'(bus.o_valid), 32'd0);
        check("lat_early_busy",  32'(bus.o_busy),  32'd1);
        tick(1);
        check("b5_valid", 32'(bus.o_valid), 32'd1);
        check("b5_code",  32'(bus.o_code),  32'd5);
        check("b5_multi", 32'(bus.o_multi), 32'd0);
        tick(1);
        check("b5_accept_valid", 32'(bus.o_valid), 32'd0);
        check("b5_accept_code",  32'(bus.o_code),  32'd0);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.o_valid !== 1'b0) hits++;
        end
        check("held_no_repeat", 32'(hits), 32'd0);
        check("held_busy", 32'(bus.o_busy), 32'd1);
        bus.i_y = 8'hFF;
        tick(5);
        check("release_not_done", 32'(bus.o_busy), 32'd1);
        tick(1);
        check("release_done", 32'(bus.o_busy), 32'd0);

        // Two requests, bit 7 wins.
        bus.i_y = 8'b0110_1111;
        wait_valid(n);
        check("b7_latency", 32'(n), 32'd7);
        check("b7_code",  32'(bus.o_code),  32'd7);
        check("b7_multi", 32'(bus.o_multi), 32'd1);
        bus.i_y = 8'hFF;
        tick(10);
        check("b7_release_busy", 32'(bus.o_busy), 32'd0);

        // Active-high polarity.
        bus.i_opt = 1'b1;
        bus.i_y   = 8'b0000_0100;
        wait_valid(n);
        check("hi_valid", 32'(bus.o_valid), 32'd1);
        check("hi_code",  32'(bus.o_code),  32'd2);
        check("hi_multi", 32'(bus.o_multi), 32'd0);
        bus.i_y = 8'h00;
        tick(10);
        check("hi_release_busy", 32'(bus.o_busy), 32'd0);
        // Return to active-low under reset so the idle lines read inactive.
        rst       = 1'b1;
        bus.i_opt = 1'b0;
        bus.i_y   = 8'hFF;
        tick(3);
        rst = 1'b0;
        tick(3);
        check("polarity_back_busy", 32'(bus.o_busy), 32'd0);

        // Glitch shorter than the debounce window.
        bus.i_y = 8'b1111_1110;
        hits = 0;
        seen_busy = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (bus.o_valid !== 1'b0) hits++;
            if (bus.o_busy === 1'b1) seen_busy = 1;
        end
        bus.i_y = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (bus.o_valid !== 1'b0) hits++;
            if (bus.o_busy === 1'b1) seen_busy = 1;
        end
        check("glitch_no_valid", 32'(hits), 32'd0);
        check("glitch_was_busy", 32'(seen_busy), 32'd1);
        check("glitch_idle", 32'(bus.o_busy), 32'd0);

        // Backpressure: hold off acceptance, change lines meanwhile.
        bus.i_ready = 1'b0;
        bus.i_y     = 8'b1111_0111;
        wait_valid(n);
        check("bp_latency", 32'(n), 32'd7);
        check("bp_code", 32'(bus.o_code), 32'd3);
        bus.i_y = 8'b0111_1111;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.o_valid !== 1'b1 || bus.o_code !== 3'd3 || bus.o_multi !== 1'b0) hits++;
        end
        check("bp_stable", 32'(hits), 32'd0);
        bus.i_y     = 8'hFF;
        bus.i_ready = 1'b1;
        tick(1);
        bus.i_ready = 1'b0;
        check("bp_pulse_valid", 32'(bus.o_valid), 32'd0);
        check("bp_pulse_code",  32'(bus.o_code),  32'd0);
        tick(8);
        check("bp_release_busy", 32'(bus.o_busy), 32'd0);
        bus.i_y = 8'b1111_1101;
        wait_valid(n);
        check("b1_latency", 32'(n), 32'd7);
        check("b1_code",  32'(bus.o_code),  32'd1);
        check("b1_multi", 32'(bus.o_multi), 32'd0);
        tick(3);
        check("b1_no_accept_hold", 32'(bus.o_valid), 32'd1);
        bus.i_ready = 1'b1;
        tick(1);
        check("b1_accept", 32'(bus.o_valid), 32'd0);
        bus.i_y = 8'hFF;
        tick(8);
        check("b1_release_busy", 32'(bus.o_busy), 32'd0);

        // Reset during S_DEBOUNCE.
        bus.i_ready = 1'b0;
        bus.i_y     = 8'b1111_1011;
        tick(4);
        check("deb_busy", 32'(bus.o_busy), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("deb_rst_valid", 32'(bus.o_valid), 32'd0);
        check("deb_rst_busy",  32'(bus.o_busy),  32'd0);
        check("deb_rst_code",  32'(bus.o_code),  32'd0);
        wait_valid(n);
        check("deb_requal_latency", 32'(n), 32'd7);
        check("deb_requal_code", 32'(bus.o_code), 32'd2);

        // Reset during S_OUTPUT, no acceptance.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("out_rst_valid", 32'(bus.o_valid), 32'd0);
        check("out_rst_busy",  32'(bus.o_busy),  32'd0);
        check("out_rst_code",  32'(bus.o_code),  32'd0);
        check("out_rst_multi", 32'(bus.o_multi), 32'd0);
        wait_valid(n);
        check("out_requal_latency", 32'(n), 32'd7);
        check("out_requal_code", 32'(bus.o_code), 32'd2);
        bus.i_ready = 1'b1;
        tick(1);
        check("final_accept", 32'(bus.o_valid), 32'd0);
        bus.i_y = 8'hFF;
        tick(8);
        check("final_idle", 32'(bus.o_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
